store_rmw_unit: RTL and testbench

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

---
 rtl/store_rmw_unit.sv | 180 ++++++++++++++++++
 tb/tb_store_rmw_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// Store read-modify-write unit: merges byte/half stores into a full memory word
// via a read, and writes whole words directly.

package store_rmw_pkg;

    localparam logic [1:0] WCONV_WORD = 2'b00;
    localparam logic [1:0] WCONV_HALF = 2'b01;
    localparam logic [1:0] WCONV_BYTE = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        return ((width == WCONV_HALF) && lane[0]) ||
               ((width == WCONV_WORD) && (lane != 2'b00));
    endfunction

    // Any width code other than WORD or HALF is treated as a byte store.
    function automatic logic [31:0] merge_word(input logic [1:0]  width,
                                               input logic [1:0]  lane,
                                               input logic [31:0] mem_word,
                                               input logic [15:0] src);
        logic [31:0] merged;
        merged = mem_word;
        if (width == WCONV_HALF) begin
            if (lane[1]) merged[31:16] = src;
            else         merged[15:0]  = src;
        end else begin
            case (lane)
                2'd0:    merged[7:0]   = src[7:0];
                2'd1:    merged[15:8]  = src[7:0];
                2'd2:    merged[23:16] = src[7:0];
                default: merged[31:24] = src[7:0];
            endcase
        end
        return merged;
    endfunction

endpackage

module store_rmw_unit
    import store_rmw_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic [1:0]        iWidthType,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iRfData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemRe,
    input  logic [31:0]       iMemRdata,
    input  logic              iMemRvalid,
    output logic              oMemWe,
    output logic [31:0]       oMemWdata,
    input  logic              iMemWack,
    output logic              oDone,
    output logic              oMisalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    state_e            state_q,     state_d;
    logic [1:0]        width_q,     width_d;
    logic [1:0]        lane_q,      lane_d;
    logic [15:0]       src_q,       src_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_re_q,    mem_re_d;
    logic              mem_we_q,    mem_we_d;
    logic              done_q,      done_d;
    logic              misalign_q,  misalign_d;
    logic              ready_q,     ready_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        width_d     = width_q;
        lane_d      = lane_q;
        src_d       = src_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iReqValid && ready_q) begin
                    if (is_misaligned(iWidthType, iAddr[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        width_d    = iWidthType;
                        lane_d     = iAddr[1:0];
                        src_d      = iRfData[15:0];
                        mem_addr_d = {iAddr[ADDR_W-1:2], 2'b00};
                        ready_d    = 1'b0;
                        if (iWidthType == WCONV_WORD) begin
                            mem_wdata_d = iRfData;
                            mem_we_d    = 1'b1;
                            state_d     = S_WRITE;
                        end else begin
                            mem_re_d = 1'b1;
                            state_d  = S_READ;
                        end
                    end
                end
            end

            S_READ: begin
                if (iMemRvalid) begin
                    mem_wdata_d = merge_word(width_q, lane_q, iMemRdata, src_q);
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end
            end

            S_WRITE: begin
                if (iMemWack) begin
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                ready_d  = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            width_q     <= WCONV_WORD;
            lane_q      <= 2'b00;
            src_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            width_q     <= width_d;
            lane_q      <= lane_d;
            src_q       <= src_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            ready_q     <= ready_d;
        end
    end

    assign oReqReady = ready_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemRe    = mem_re_q;
    assign oMemWe    = mem_we_q;
    assign oMemWdata = mem_wdata_q;
    assign oDone     = done_q;
    assign oMisalign = misalign_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: directed vector table, stall/reset
// sequences and randomized stores checked against a byte-lane reference model.

module tb_store_rmw_unit;
    import store_rmw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iReqValid = 1'b0;
    logic        oReqReady;
    logic [1:0]  iWidthType = 2'b00;
    logic [31:0] iAddr = '0;
    logic [31:0] iRfData = '0;
    logic [31:0] oMemAddr;
    logic        oMemRe;
    logic [31:0] iMemRdata = '0;
    logic        iMemRvalid = 1'b0;
    logic        oMemWe;
    logic [31:0] oMemWdata;
    logic        iMemWack = 1'b0;
    logic        oDone;
    logic        oMisalign;

    int    total = 0;
    int    bad = 0;
    string tag = "reset";

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iReqValid  (iReqValid),
        .oReqReady  (oReqReady),
        .iWidthType (iWidthType),
        .iAddr      (iAddr),
        .iRfData    (iRfData),
        .oMemAddr   (oMemAddr),
        .oMemRe     (oMemRe),
        .iMemRdata  (iMemRdata),
        .iMemRvalid (iMemRvalid),
        .oMemWe     (oMemWe),
        .oMemWdata  (oMemWdata),
        .iMemWack   (iMemWack),
        .oDone      (oDone),
        .oMisalign  (oMisalign)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %b expected %b", tag, name, act, exp);
        end
    endtask

    // Reference: lay the memory word out as bytes and overwrite the stored lanes.
    function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] a,
                                                input logic [31:0] d, input logic [31:0] mem);
        logic [7:0] b [4];
        int n;
        int off;
        for (int k = 0; k < 4; k++) b[k] = mem[8*k +: 8];
        n   = (w == WCONV_BYTE) ? 1 : (w == WCONV_HALF) ? 2 : 4;
        off = (w == WCONV_WORD) ? 0 : int'(a % 4);
        for (int k = 0; k < n; k++) b[off + k] = d[8*k +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic model_misalign(input logic [1:0] w, input logic [31:0] a);
        return (w == WCONV_HALF && (a % 2) != 0) || (w == WCONV_WORD && (a % 4) != 0);
    endfunction

    // Issue one store at the current negedge and follow it to completion.
    // Returns at the negedge where oDone is expected high, so the next call
    // issues its request in the oDone cycle.
    task automatic run_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] mem, input int rdly, input int wdly,
                             input logic exp_mis, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_addr);
        check1("ready_at_req", oReqReady, 1'b1);
        iReqValid  = 1'b1;
        iWidthType = w;
        iAddr      = a;
        iRfData    = d;
        @(negedge clk);
        iReqValid = 1'b0;
        iAddr     = $urandom;
        iRfData   = $urandom;

        if (exp_mis) begin
            check1("misalign", oMisalign, 1'b1);
            check1("mis_re", oMemRe, 1'b0);
            check1("mis_we", oMemWe, 1'b0);
            check1("mis_done", oDone, 1'b0);
            check1("mis_ready", oReqReady, 1'b1);
            @(negedge clk);
            check1("misalign_end", oMisalign, 1'b0);
            check1("mis_re2", oMemRe, 1'b0);
            check1("mis_we2", oMemWe, 1'b0);
            check1("mis_done2", oDone, 1'b0);
            return;
        end

        if (w != WCONV_WORD) begin
            for (int i = 0; i <= rdly; i++) begin
                check1("rd_re", oMemRe, 1'b1);
                check1("rd_we", oMemWe, 1'b0);
                check1("rd_ready", oReqReady, 1'b0);
                check1("rd_done", oDone, 1'b0);
                check1("rd_misalign", oMisalign, 1'b0);
                check32("rd_addr", oMemAddr, exp_addr);
                iMemRvalid = (i == rdly);
                iMemWack   = (i != rdly) ? 1'($urandom_range(0, 1)) : 1'b0;
                iMemRdata  = (i == rdly) ? mem : $urandom;
                @(negedge clk);
            end
            iMemRvalid = 1'b0;
            iMemWack   = 1'b0;
        end

        for (int i = 0; i <= wdly; i++) begin
            check1("wr_we", oMemWe, 1'b1);
            check1("wr_re", oMemRe, 1'b0);
            check1("wr_ready", oReqReady, 1'b0);
            check1("wr_done", oDone, 1'b0);
            check32("wr_addr", oMemAddr, exp_addr);
            check32("wr_data", oMemWdata, exp_wdata);
            iMemWack   = (i == wdly);
            iMemRvalid = (i != wdly) ? 1'($urandom_range(0, 1)) : 1'b0;
            iMemRdata  = $urandom;
            @(negedge clk);
        end
        iMemWack   = 1'b0;
        iMemRvalid = 1'b0;

        check1("done", oDone, 1'b1);
        check1("done_ready", oReqReady, 1'b1);
        check1("done_we", oMemWe, 1'b0);
        check1("done_re", oMemRe, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] mem;
        int          rdly;
        int          wdly;
        logic        mis;
        logic [31:0] wdata;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"word_100",    WCONV_WORD, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 32'hDEADBEEF, 32'h100};
        vecs[1]  = '{"byte_203",    WCONV_BYTE, 32'h203, 32'h000000AA, 32'h11223344, 0, 0, 1'b0, 32'hAA223344, 32'h200};
        vecs[2]  = '{"half_302",    WCONV_HALF, 32'h302, 32'h0000BEEF, 32'h11223344, 0, 0, 1'b0, 32'hBEEF3344, 32'h300};
        vecs[3]  = '{"half_mis101", WCONV_HALF, 32'h101, 32'h12345678, 32'h0,        0, 0, 1'b1, 32'h0,        32'h0};
        vecs[4]  = '{"byte_400",    WCONV_BYTE, 32'h400, 32'h12345677, 32'h11223344, 1, 0, 1'b0, 32'h11223377, 32'h400};
        vecs[5]  = '{"byte_401",    WCONV_BYTE, 32'h401, 32'h00000055, 32'hA0B0C0D0, 0, 1, 1'b0, 32'hA0B055D0, 32'h400};
        vecs[6]  = '{"half_500",    WCONV_HALF, 32'h500, 32'hFFFF1234, 32'hCAFEBABE, 2, 0, 1'b0, 32'hCAFE1234, 32'h500};
        vecs[7]  = '{"word_mis602", WCONV_WORD, 32'h602, 32'h11111111, 32'h0,        0, 0, 1'b1, 32'h0,        32'h0};
        vecs[8]  = '{"word_mis703", WCONV_WORD, 32'h703, 32'h22222222, 32'h0,        0, 0, 1'b1, 32'h0,        32'h0};
        vecs[9]  = '{"byte_002",    WCONV_BYTE, 32'h002, 32'h00000000, 32'hFFFFFFFF, 0, 0, 1'b0, 32'hFF00FFFF, 32'h000};
        vecs[10] = '{"half_stall",  WCONV_HALF, 32'h802, 32'h00009876, 32'h01020304, 5, 3, 1'b0, 32'h98760304, 32'h800};
        vecs[11] = '{"word_900",    WCONV_WORD, 32'h900, 32'h01234567, 32'h0,        0, 2, 1'b0, 32'h01234567, 32'h900};

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check1("ready", oReqReady, 1'b1);
        check1("re", oMemRe, 1'b0);
        check1("we", oMemWe, 1'b0);
        check1("done", oDone, 1'b0);
        check1("misalign", oMisalign, 1'b0);
        check32("addr", oMemAddr, 32'h0);
        check32("wdata", oMemWdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, issued back to back (new request in the oDone cycle).
        foreach (vecs[i]) begin
            tag = vecs[i].name;
            run_store(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].mem, vecs[i].rdly, vecs[i].wdly,
                      vecs[i].mis, vecs[i].wdata, vecs[i].addr);
        end
        @(negedge clk);
        tag = "after_table";
        check1("done_pulse_end", oDone, 1'b0);

        // Reset while a byte store sits in READ.
        tag = "rst_mid_read";
        iReqValid  = 1'b1;
        iWidthType = WCONV_BYTE;
        iAddr      = 32'h203;
        iRfData    = 32'hAA;
        @(negedge clk);
        iReqValid = 1'b0;
        check1("re_before", oMemRe, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("re", oMemRe, 1'b0);
        check1("we", oMemWe, 1'b0);
        check1("ready", oReqReady, 1'b1);
        check1("done", oDone, 1'b0);
        check32("addr", oMemAddr, 32'h0);
        check32("wdata", oMemWdata, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        iMemRvalid = 1'b1;
        iMemRdata  = 32'h11223344;
        @(negedge clk);
        iMemRvalid = 1'b0;
        iMemWack   = 1'b1;
        check1("stray_rvalid_re", oMemRe, 1'b0);
        check1("stray_rvalid_we", oMemWe, 1'b0);
        check1("no_done", oDone, 1'b0);
        @(negedge clk);
        iMemWack = 1'b0;
        check1("stray_wack_done", oDone, 1'b0);
        check1("ready_after", oReqReady, 1'b1);
        tag = "after_rst";
        run_store(WCONV_BYTE, 32'h203, 32'hAA, 32'h11223344, 0, 0, 1'b0, 32'hAA223344, 32'h200);

        // Randomized stores against the byte-lane model.
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  w;
            logic [31:0] a, d, mem;
            w   = 2'($urandom_range(0, 2));
            a   = $urandom;
            d   = $urandom;
            mem = $urandom;
            if ($urandom_range(0, 3) != 0 && w == WCONV_WORD) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0 && w == WCONV_HALF) a[0]   = 1'b0;
            tag = $sformatf("rand%0d", n);
            run_store(w, a, d, mem, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      model_misalign(w, a), model_wdata(w, a, d, mem), a & ~32'h3);
        end
        @(negedge clk);
        tag = "final";
        check1("done_pulse_end", oDone, 1'b0);
        check1("idle_ready", oReqReady, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
